// File: rtl/nanoz80_uart.sv
// nano-z80 buffered UART: TX/RX FIFOs, fixed-baud 8N1 transmitter and receiver,
// and the status/control register set at I/O ports 0x70-0x73.

module nanoz80_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [7:0]             data_i,
  output logic [7:0]             data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          doPush;
  logic          doPop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign doPop   = pop_i & ~empty_o;
  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign doPush  = push_i & (~full | doPop);
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop) rdPtr_d = rdPtr_q + AW'(1);
      if (doPush && !doPop) count_d = count_q + CW'(1);
      else if (doPop && !doPush) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end
endmodule

module nanoz80_uart #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cs_i,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [1:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  input  logic       uart_rx_i,
  output logic       uart_tx_o
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int DW   = $clog2(DIV);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          wrActive, wrActive_q, wrEvent;
  logic          rdActive, rdActive_q, rdEvent;
  logic [1:0]    rdAddr_q;
  logic          ctrlWr, flushRx, flushTx, clrSticky;
  logic          txPush, txPop, txEmpty, txFull, txIdle;
  logic [7:0]    txHead;
  logic [CW-1:0] txCount;
  logic          rxPush, rxPop, rxEmpty, rxFull;
  logic [7:0]    rxHead;
  logic [CW-1:0] rxCount;

  logic [1:0]    txState_q, txState_d;
  logic [DW-1:0] txDiv_q, txDiv_d;
  logic [2:0]    txBit_q, txBit_d;
  logic [7:0]    txShift_q, txShift_d;
  logic          txLine_q, txLine_d;
  logic          txDone;

  logic [1:0]    rxSync_q;
  logic          rxPrev_q, rxS;
  logic [1:0]    rxState_q, rxState_d;
  logic [DW-1:0] rxDiv_q, rxDiv_d;
  logic [2:0]    rxBit_q, rxBit_d;
  logic [7:0]    rxShift_q, rxShift_d;
  logic          rxDone;
  logic          setOverrun, setFrameErr;
  logic          overrun_q, frameErr_q;
  logic [7:0]    status;

  // Writes act on the leading edge of the strobe; reads act on the trailing edge
  // so the returned data stays stable for the whole access.
  assign wrActive  = cs_i & ~wr_n;
  assign rdActive  = cs_i & ~rd_n;
  assign wrEvent   = wrActive & ~wrActive_q;
  assign rdEvent   = rdActive_q & ~rdActive;
  assign txPush    = wrEvent & (addr_i == 2'd0);
  assign ctrlWr    = wrEvent & (addr_i == 2'd2);
  assign flushRx   = ctrlWr & data_i[0];
  assign flushTx   = ctrlWr & data_i[1];
  assign clrSticky = ctrlWr & data_i[2];
  assign rxPop     = rdEvent & (rdAddr_q == 2'd0);
  assign txFull    = (txCount == CW'(FIFO_DEPTH));
  assign rxFull    = (rxCount == CW'(FIFO_DEPTH));
  assign txIdle    = txEmpty & (txState_q == TX_IDLE);
  assign txDone    = (txDiv_q == DW'(DIV - 1));
  assign rxDone    = (rxDiv_q == DW'(DIV - 1));
  assign rxS       = rxSync_q[1];
  assign uart_tx_o = txLine_q;
  assign status    = {3'b000, frameErr_q, overrun_q, txIdle, txFull, ~rxEmpty};

  nanoz80_uart_fifo #(.DEPTH(FIFO_DEPTH)) txFifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (txPush),
    .pop_i   (txPop),
    .flush_i (flushTx),
    .data_i  (data_i),
    .data_o  (txHead),
    .count_o (txCount),
    .empty_o (txEmpty)
  );

  nanoz80_uart_fifo #(.DEPTH(FIFO_DEPTH)) rxFifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (rxPush),
    .pop_i   (rxPop),
    .flush_i (flushRx),
    .data_i  (rxShift_d),
    .data_o  (rxHead),
    .count_o (rxCount),
    .empty_o (rxEmpty)
  );

  always_comb begin
    data_o = 8'h00;
    if (rdActive) begin
      case (addr_i)
        2'd0:    data_o = rxEmpty ? 8'h00 : rxHead;
        2'd1:    data_o = status;
        2'd3:    data_o = 8'(rxCount);
        default: data_o = 8'h00;
      endcase
    end
  end

  // A flush in the same cycle blocks the FSM from loading a byte the flush discards.
  always_comb begin
    txState_d = txState_q;
    txDiv_d   = txDiv_q;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPop     = 1'b0;
    case (txState_q)
      TX_IDLE: begin
        if (!txEmpty && !flushTx) begin
          txState_d = TX_START;
          txDiv_d   = '0;
          txShift_d = txHead;
          txPop     = 1'b1;
        end
      end
      TX_START: begin
        txDiv_d = txDiv_q + DW'(1);
        if (txDone) begin
          txState_d = TX_DATA;
          txDiv_d   = '0;
          txBit_d   = '0;
        end
      end
      TX_DATA: begin
        txDiv_d = txDiv_q + DW'(1);
        if (txDone) begin
          txDiv_d   = '0;
          txShift_d = {1'b0, txShift_q[7:1]};
          txBit_d   = txBit_q + 3'd1;
          if (txBit_q == 3'd7) txState_d = TX_STOP;
        end
      end
      default: begin
        txDiv_d = txDiv_q + DW'(1);
        if (txDone) begin
          if (!txEmpty && !flushTx) begin
            txState_d = TX_START;
            txDiv_d   = '0;
            txShift_d = txHead;
            txPop     = 1'b1;
          end else begin
            txState_d = TX_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    case (txState_q)
      TX_START: txLine_d = 1'b0;
      TX_DATA:  txLine_d = txShift_q[0];
      default:  txLine_d = 1'b1;
    endcase
  end

  // Start is confirmed half a bit after the falling edge; data and stop bits
  // are then sampled one full bit apart, i.e. mid-bit.
  always_comb begin
    rxState_d   = rxState_q;
    rxDiv_d     = rxDiv_q;
    rxBit_d     = rxBit_q;
    rxShift_d   = rxShift_q;
    rxPush      = 1'b0;
    setOverrun  = 1'b0;
    setFrameErr = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        if (rxPrev_q && !rxS) begin
          rxState_d = RX_START;
          rxDiv_d   = '0;
        end
      end
      RX_START: begin
        rxDiv_d = rxDiv_q + DW'(1);
        if (rxDiv_q == DW'(HALF - 1)) begin
          rxDiv_d   = '0;
          rxBit_d   = '0;
          rxState_d = rxS ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rxDiv_d = rxDiv_q + DW'(1);
        if (rxDone) begin
          rxDiv_d   = '0;
          rxShift_d = {rxS, rxShift_q[7:1]};
          rxBit_d   = rxBit_q + 3'd1;
          if (rxBit_q == 3'd7) rxState_d = RX_STOP;
        end
      end
      default: begin
        rxDiv_d = rxDiv_q + DW'(1);
        if (rxDone) begin
          rxState_d = RX_IDLE;
          if (rxS) begin
            rxPush     = 1'b1;
            setOverrun = rxFull & ~rxPop;
          end else begin
            setFrameErr = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wrActive_q <= 1'b0;
      rdActive_q <= 1'b0;
      rdAddr_q   <= 2'd0;
      txState_q  <= TX_IDLE;
      txDiv_q    <= '0;
      txBit_q    <= '0;
      txShift_q  <= '0;
      txLine_q   <= 1'b1;
      rxSync_q   <= 2'b11;
      rxPrev_q   <= 1'b1;
      rxState_q  <= RX_IDLE;
      rxDiv_q    <= '0;
      rxBit_q    <= '0;
      rxShift_q  <= '0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      wrActive_q <= wrActive;
      rdActive_q <= rdActive;
      if (rdActive) rdAddr_q <= addr_i;
      txState_q  <= txState_d;
      txDiv_q    <= txDiv_d;
      txBit_q    <= txBit_d;
      txShift_q  <= txShift_d;
      txLine_q   <= txLine_d;
      rxSync_q   <= {rxSync_q[0], uart_rx_i};
      rxPrev_q   <= rxS;
      rxState_q  <= rxState_d;
      rxDiv_q    <= rxDiv_d;
      rxBit_q    <= rxBit_d;
      rxShift_q  <= rxShift_d;
      overrun_q  <= (overrun_q & ~clrSticky) | setOverrun;
      frameErr_q <= (frameErr_q & ~clrSticky) | setFrameErr;
    end
  end
endmodule

// File: tb/tb_nanoz80_uart.sv
// Self-checking bench for nanoz80_uart: CPU-port accesses, TX line decoding and
// RX frame driving, compared against a queue-based model of the register set.

module tb_nanoz80_uart;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs    = 1'b0;
  logic       wr_n  = 1'b1;
  logic       rd_n  = 1'b1;
  logic [1:0] addr  = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic       rx    = 1'b1;
  logic [7:0] rdata;
  logic       tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] rxQ[$];
  bit         ovModel = 1'b0;
  bit         feModel = 1'b0;

  int         monStart[$];
  logic [7:0] monByte[$];
  logic       monStop[$];

  nanoz80_uart #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .cs_i      (cs),
    .wr_n      (wr_n),
    .rd_n      (rd_n),
    .addr_i    (addr),
    .data_i    (wdata),
    .data_o    (rdata),
    .uart_rx_i (rx),
    .uart_tx_o (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decodes every 8N1 frame on the TX line, sampling mid-bit from the first low cycle.
  initial begin : txMonitor
    logic [7:0] b;
    int s;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        s = cyc;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        monStop.push_back(tx);
        monByte.push_back(b);
        monStart.push_back(s);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic cpuWrite(input logic [1:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    cs = 1'b1;
    wr_n = 1'b0;
    addr = a;
    wdata = d;
    repeat (hold) @(negedge clk);
    cs = 1'b0;
    wr_n = 1'b1;
  endtask

  task automatic cpuRead(input logic [1:0] a, input int hold, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1;
    rd_n = 1'b0;
    addr = a;
    #1 d = rdata;
    repeat (hold) @(negedge clk);
    cs = 1'b0;
    rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stopBit);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stopBit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  function automatic void modelFrame(input logic [7:0] d, input logic stopBit);
    if (!stopBit) feModel = 1'b1;
    else if (rxQ.size() < DEPTH) rxQ.push_back(d);
    else ovModel = 1'b1;
  endfunction

  function automatic logic [7:0] expStatus(input logic txIdle, input logic txFull);
    return {3'b000, feModel, ovModel, txIdle, txFull, rxQ.size() != 0};
  endfunction

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic [9:0] frame;
    logic       expBit;
    logic [7:0] sent[$];
    int         c;
    int         t;
    int         lows;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("resetTx", tx, 1'b1);
    checkOutput("resetDataO", rdata, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cpuRead(2'd1, 1, d);
    checkOutput("resetStatus", d, expStatus(1'b1, 1'b0));
    cpuRead(2'd3, 1, d);
    checkOutput("resetRxCount", d, 8'd0);
    cpuRead(2'd0, 1, d);
    checkOutput("emptyRxRead", d, 8'h00);
    @(negedge clk);
    rd_n = 1'b0;
    addr = 2'd1;
    #1 checkOutput("dataONoCs", rdata, 8'h00);
    rd_n = 1'b1;

    // Exact TX waveform of 0x55, start bit two edges after the push edge
    $display("[TB] tx waveform 0x55");
    @(negedge clk);
    c = cyc;
    cs = 1'b1;
    wr_n = 1'b0;
    addr = 2'd0;
    wdata = 8'h55;
    @(negedge clk);
    cs = 1'b0;
    wr_n = 1'b1;
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < FRAME + 4; k++) begin
      t = cyc - (c + 3);
      expBit = (t >= 0 && t < FRAME) ? frame[t / DIV] : 1'b1;
      checkOutput("txWave", tx, expBit);
      @(negedge clk);
    end
    cpuRead(2'd1, 1, d);
    checkOutput("txIdleAfter", d, expStatus(1'b1, 1'b0));
    checkOutput("mon55", monByte[0], 8'h55);
    monByte.delete();
    monStart.delete();
    monStop.delete();

    // Back-to-back frames from long-held write strobes
    $display("[TB] back-to-back tx");
    cpuWrite(2'd0, 8'hA5, 4);
    cpuWrite(2'd0, 8'h3C, 4);
    cpuRead(2'd1, 1, d);
    checkOutput("busyStatus", d, expStatus(1'b0, 1'b0));
    repeat (2 * FRAME + 30) @(negedge clk);
    checkOutput("b2bCount", monByte.size(), 2);
    checkOutput("b2bByte0", monByte[0], 8'hA5);
    checkOutput("b2bByte1", monByte[1], 8'h3C);
    checkOutput("b2bStop", {monStop[0], monStop[1]}, 2'b11);
    checkOutput("b2bGap", monStart[1] - monStart[0], FRAME);
    monByte.delete();
    monStart.delete();
    monStop.delete();

    // 18 writes while the first is in flight: 17 frames, last write dropped
    $display("[TB] tx fifo fill");
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      cpuWrite(2'd0, b, 1);
    end
    cpuRead(2'd1, 1, d);
    checkOutput("txFullStatus", d, expStatus(1'b0, 1'b1));
    repeat (17 * FRAME + 50) @(negedge clk);
    checkOutput("fillCount", monByte.size(), 17);
    for (int i = 0; i < 17; i++) checkOutput("fillByte", monByte[i], sent[i]);
    for (int i = 1; i < 17; i++) checkOutput("fillGap", monStart[i] - monStart[i-1], FRAME);
    cpuRead(2'd1, 1, d);
    checkOutput("fillIdle", d, expStatus(1'b1, 1'b0));

    // Single RX frame and a long-held read
    $display("[TB] rx single frame");
    applyStimulus(8'hC3, 1'b1);
    modelFrame(8'hC3, 1'b1);
    repeat (5) @(negedge clk);
    cpuRead(2'd1, 1, d);
    checkOutput("rxAvail", d, expStatus(1'b1, 1'b0));
    cpuRead(2'd3, 1, d);
    checkOutput("rxCount1", d, rxQ.size());
    cpuRead(2'd0, 5, d);
    checkOutput("rxByte", d, rxQ[0]);
    void'(rxQ.pop_front());
    cpuRead(2'd3, 1, d);
    checkOutput("rxCount0", d, rxQ.size());
    cpuRead(2'd1, 1, d);
    checkOutput("rxDrained", d, expStatus(1'b1, 1'b0));

    // 17 frames without reading: overrun, first 16 kept
    $display("[TB] rx overrun");
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      applyStimulus(b, 1'b1);
      modelFrame(b, 1'b1);
    end
    repeat (5) @(negedge clk);
    cpuRead(2'd3, 1, d);
    checkOutput("rxCountFull", d, rxQ.size());
    cpuRead(2'd1, 1, d);
    checkOutput("overrunStatus", d, expStatus(1'b1, 1'b0));
    while (rxQ.size() != 0) begin
      cpuRead(2'd0, 1, d);
      checkOutput("rxOrder", d, rxQ.pop_front());
    end
    cpuRead(2'd1, 1, d);
    checkOutput("overrunSticky", d, expStatus(1'b1, 1'b0));
    cpuWrite(2'd2, 8'h04, 1);
    ovModel = 1'b0;
    cpuRead(2'd1, 1, d);
    checkOutput("overrunClear", d, expStatus(1'b1, 1'b0));

    // Framing error and glitch rejection
    $display("[TB] rx framing and glitch");
    applyStimulus(8'h5A, 1'b0);
    modelFrame(8'h5A, 1'b0);
    repeat (5) @(negedge clk);
    cpuRead(2'd1, 1, d);
    checkOutput("framingStatus", d, expStatus(1'b1, 1'b0));
    cpuRead(2'd3, 1, d);
    checkOutput("framingNoPush", d, rxQ.size());
    cpuWrite(2'd2, 8'h04, 1);
    feModel = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    cpuRead(2'd3, 1, d);
    checkOutput("glitchNoPush", d, rxQ.size());
    cpuRead(2'd1, 1, d);
    checkOutput("glitchStatus", d, expStatus(1'b1, 1'b0));

    // Flushes
    $display("[TB] flushes");
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      applyStimulus(b, 1'b1);
      modelFrame(b, 1'b1);
    end
    repeat (5) @(negedge clk);
    cpuRead(2'd3, 1, d);
    checkOutput("preFlushCount", d, rxQ.size());
    cpuWrite(2'd2, 8'h01, 1);
    rxQ.delete();
    cpuRead(2'd3, 1, d);
    checkOutput("rxFlush", d, rxQ.size());
    monByte.delete();
    monStart.delete();
    monStop.delete();
    cpuWrite(2'd0, 8'h81, 1);
    cpuWrite(2'd0, 8'h42, 1);
    cpuWrite(2'd0, 8'h24, 1);
    cpuWrite(2'd2, 8'h02, 1);
    repeat (3 * FRAME + 50) @(negedge clk);
    checkOutput("txFlushCount", monByte.size(), 1);
    checkOutput("txFlushByte", monByte[0], 8'h81);

    // Reset in the middle of a TX frame
    $display("[TB] reset mid-frame");
    applyStimulus(8'h99, 1'b1);
    cpuWrite(2'd0, 8'h00, 1);
    cpuWrite(2'd0, 8'hFF, 1);
    cpuWrite(2'd0, 8'hFF, 1);
    repeat (30) @(negedge clk);
    checkOutput("txLowPreReset", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("txAsyncReset", tx, 1'b1);
    rxQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cpuRead(2'd3, 1, d);
    checkOutput("resetRxEmpty", d, 8'd0);
    cpuRead(2'd1, 1, d);
    checkOutput("resetStatus2", d, 8'h04);
    lows = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checkOutput("resetTxQuiet", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
